// File: rtl/opaque_serial_tx.sv
// Opaque serial transmitter: UART-style framing (start, N data bits LSB first,
// optional parity, 1 or 2 stop bits) with Cts flow control and a registered Tx.
module opaque_serial_tx #(
    parameter int N            = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic         Clock,
    input  logic         Reset,
    input  logic [N-1:0] Din,
    input  logic         Din_send,
    output logic         Din_ready,
    output logic         Din_finish,
    input  logic         Cts,
    output logic         Tx,
    output logic         Busy
);

    localparam int               CNT_W      = $clog2(N + 1);
    localparam logic [15:0]      BAUD_MAX   = 16'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] LAST_BIT   = CNT_W'(N);
    localparam logic             ODD_BIT    = (PARITY_ODD != 0);
    localparam bit               HAS_PARITY = (PARITY_EN != 0);
    localparam bit               TWO_STOP   = (STOP_BITS == 2);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t             state_q, state_d;
    logic [15:0]        baud_q, baud_d;
    logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [N-1:0]       shift_q, shift_d;
    logic               par_q, par_d;
    logic               stop2_q, stop2_d;
    logic               tx_q, tx_d;
    logic               finish_q, finish_d;

    assign Din_ready  = (state_q == IDLE) && Cts;
    assign Busy       = (state_q != IDLE);
    assign Tx         = tx_q;
    assign Din_finish = finish_q;

    // Next-state logic: each bit boundary is the edge where the baud counter is 0;
    // Tx is set to the value of the bit being entered so it comes straight off a flop.
    always_comb begin
        state_d   = state_q;
        baud_d    = baud_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        par_d     = par_q;
        stop2_d   = stop2_q;
        tx_d      = tx_q;
        finish_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (Din_send && Din_ready) begin
                    state_d   = START;
                    shift_d   = Din;
                    // Parity is captured up front because the shifter empties during DATA.
                    par_d     = (^Din) ^ ODD_BIT;
                    baud_d    = BAUD_MAX;
                    bit_cnt_d = '0;
                    stop2_d   = 1'b0;
                    tx_d      = 1'b0;
                end
            end

            START: begin
                if (baud_q == '0) begin
                    state_d   = DATA;
                    baud_d    = BAUD_MAX;
                    tx_d      = shift_q[0];
                    shift_d   = shift_q >> 1;
                    bit_cnt_d = {{(CNT_W-1){1'b0}}, 1'b1};
                end else begin
                    baud_d = baud_q - 1'b1;
                end
            end

            DATA: begin
                if (baud_q == '0) begin
                    baud_d = BAUD_MAX;
                    if (bit_cnt_q == LAST_BIT) begin
                        if (HAS_PARITY) begin
                            state_d = PARITY;
                            tx_d    = par_q;
                        end else begin
                            state_d = STOP;
                            tx_d    = 1'b1;
                            stop2_d = 1'b0;
                        end
                    end else begin
                        tx_d      = shift_q[0];
                        shift_d   = shift_q >> 1;
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end else begin
                    baud_d = baud_q - 1'b1;
                end
            end

            PARITY: begin
                if (baud_q == '0) begin
                    state_d = STOP;
                    baud_d  = BAUD_MAX;
                    tx_d    = 1'b1;
                    stop2_d = 1'b0;
                end else begin
                    baud_d = baud_q - 1'b1;
                end
            end

            STOP: begin
                if (baud_q == '0) begin
                    if (TWO_STOP && !stop2_q) begin
                        stop2_d = 1'b1;
                        baud_d  = BAUD_MAX;
                    end else begin
                        state_d   = IDLE;
                        finish_d  = 1'b1;
                        tx_d      = 1'b1;
                        bit_cnt_d = '0;
                        stop2_d   = 1'b0;
                        baud_d    = '0;
                    end
                end else begin
                    baud_d = baud_q - 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
            end
        endcase
    end

    // State registers; asynchronous reset returns the line to idle-high at once.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q   <= IDLE;
            baud_q    <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            par_q     <= 1'b0;
            stop2_q   <= 1'b0;
            tx_q      <= 1'b1;
            finish_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            baud_q    <= baud_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            par_q     <= par_d;
            stop2_q   <= stop2_d;
            tx_q      <= tx_d;
            finish_q  <= finish_d;
        end
    end

endmodule

// File: doc/opaque_serial_tx.md
OPAQUE_SERIAL_TX -- requirements
Module: opaque_serial_tx

Interface
REQ-001 Parameter: N, default 8, data word width in bits.
REQ-002 Parameter: CLKS_PER_BIT, default 16, Clock cycles per serial bit; legal range 2..65535.
REQ-003 Parameter: PARITY_EN, default 0, 1 appends a parity bit after the data bits.
REQ-004 Parameter: PARITY_ODD, default 0, 1 selects odd parity, 0 selects even parity; ignored when PARITY_EN=0.
REQ-005 Parameter: STOP_BITS, default 1, number of stop bits; legal values 1 or 2.
REQ-006 Clock  input  1  clock; all state SHALL change on the rising edge.
REQ-007 Reset  input  1  reset; asynchronous, active-low.
REQ-008 Din  input  N  word to transmit; sampled only on acceptance.
REQ-009 Din_send  input  1  request to transmit Din; level-sensitive, qualified by Din_ready.
REQ-010 Din_ready  output  1  high when a new word can be accepted.
REQ-011 Din_finish  output  1  one-cycle pulse when a frame has fully left the line.
REQ-012 Cts  input  1  clear-to-send; when low, no new frame may start.
REQ-013 Tx  output  1  serial line; idles high.
REQ-014 Busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-015 The FSM SHALL have the states IDLE, START, DATA, PARITY and STOP, and it SHALL skip PARITY when PARITY_EN=0.
REQ-016 Din_ready SHALL be combinational and SHALL equal (state==IDLE) && Cts.
REQ-017 Acceptance SHALL occur on any rising edge where Din_send && Din_ready; the FSM SHALL then latch Din into a shift register and enter START.
REQ-018 Din_send SHALL be ignored while Din_ready is low, with no queuing and no error indication.
REQ-019 Changes on Din after acceptance SHALL NOT affect the frame in progress.
REQ-020 Tx SHALL be driven from a register (glitch-free) and SHALL be 1 in IDLE.
REQ-021 START SHALL drive Tx=0 for exactly CLKS_PER_BIT cycles, beginning in the cycle after acceptance.
REQ-022 DATA SHALL shift out the N bits LSB first, each held for CLKS_PER_BIT cycles.
REQ-023 A bit counter SHALL be sized ceil(log2(N+1)) bits.
REQ-024 PARITY SHALL drive Tx = XOR of the latched word, XOR PARITY_ODD, for CLKS_PER_BIT cycles.
REQ-025 STOP SHALL drive Tx=1 for STOP_BITS*CLKS_PER_BIT cycles.
REQ-026 Frame length SHALL be exactly (1+N+PARITY_EN+STOP_BITS)*CLKS_PER_BIT cycles from the first START cycle to the last STOP cycle.
REQ-027 The baud counter SHALL count CLKS_PER_BIT-1 down to 0 with no drift across bits.
REQ-028 The baud counter SHALL reload at every bit boundary.
REQ-029 On the edge ending the last STOP cycle, the FSM SHALL return to IDLE and Din_finish SHALL be registered high for exactly that following cycle.
REQ-030 In the cycle Din_finish is high, Din_ready SHALL be high if Cts is high.
REQ-031 An acceptance in the Din_finish cycle SHALL start the next frame with no idle bit between frames.
REQ-032 Cts falling mid-frame SHALL NOT abort or stretch the frame, and the block SHALL block only the next acceptance.
REQ-033 Cts rising SHALL take effect combinationally on Din_ready.
REQ-034 Din_finish SHALL pulse exactly once per accepted word and never otherwise.

Reset
REQ-035 While Reset is low, the block SHALL hold state IDLE, Tx=1, Busy=0, Din_finish=0, all counters 0 and the shift register 0.
REQ-036 In reset, Din_ready SHALL follow Cts.
REQ-037 Reset asserted mid-frame SHALL force Tx=1 immediately (asynchronously), abandon the frame and emit no Din_finish.
REQ-038 After reset deassertion, the first acceptance SHALL behave as from power-up.

Verification
REQ-039 N=8, CLKS_PER_BIT=4, no parity, 1 stop, Cts=1; send 0xA5 -> Tx = 0,1,0,1,0,0,1,0,1,1 with each bit held 4 cycles; Busy high for 40 cycles; Din_finish pulses once in cycle 41.
REQ-040 PARITY_EN=1, send 0x07 -> parity bit 1 with PARITY_ODD=0, 0 with PARITY_ODD=1; frame is 44 cycles.
REQ-041 Din_send held high continuously with Din toggling 0x00/0xFF -> back-to-back frames, no idle gap, each frame carrying the Din value at its acceptance edge.
REQ-042 Cts=0, pulse Din_send -> Tx stays 1 and Din_ready=0; Cts low mid-frame -> frame completes and Din_finish pulses.
REQ-043 STOP_BITS=2, CLKS_PER_BIT=3 -> stop high for 6 cycles; frame is 33 cycles.
REQ-044 Reset pulsed during DATA bit 3 -> Tx=1 within the same cycle, no Din_finish, and a new send afterwards is transmitted correctly.
